// File: rtl/dcache_ctrl_nway.sv
// N-way set-associative data-cache controller: hit path, victim selection, writeback/fill FSM.
// Optional perf counters (hitCnt/missCnt/wbCnt) are compiled in when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl_nway #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int WAYS        = 2,
  parameter int TAG_W       = 20,
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int BLK_B      = BLOCK_WORDS * WORD_W,
  localparam int OFF_W      = $clog2(BLK_B / 8),
  localparam int MA_W       = ADDR_W - OFF_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ren,
  input  logic               wen,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WORD_W/8-1:0] byteSel,
  input  logic [WORD_W-1:0]  din,
  output logic               stall,
  output logic [WORD_W-1:0]  dout,
  input  logic [WAYS-1:0]    wayHit,
  input  logic [WAYS-1:0]    wayValid,
  input  logic [WAYS-1:0]    wayDirty,
  input  logic [TAG_W-1:0]   victimTag,
  input  logic [BLK_B-1:0]   cacheDout,
  output logic [WAY_W-1:0]   cacheWay,
  output logic               cacheRen,
  output logic               cacheWen,
  output logic               cacheFillWen,
  output logic [BLK_B/8-1:0] cacheBytesAccess,
  output logic [BLK_B-1:0]   cacheDin,
  output logic               memRen,
  output logic               memWen,
  output logic [MA_W-1:0]    memAddr,
  output logic [BLK_B-1:0]   memDin,
  input  logic [BLK_B-1:0]   memDout,
  input  logic               memReadReady,
  input  logic               memWriteDone
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hitCnt,
  output logic [31:0]        missCnt,
  output logic [31:0]        wbCnt
`endif
);

  localparam int NB     = WORD_W / 8;
  localparam int BYTE_W = $clog2(NB);
  localparam int SET_W  = MA_W - TAG_W;

  typedef enum logic [2:0] {IDLE, WRITEBACK, MEMREAD, FILL, REPLAY} state_t;

  state_t            state, next_state;
  logic [WAY_W-1:0]  rr, vway, vway_d, hit_way, victim;
  logic              req, hit, wen_only, hit_found, inv_found;
  logic [ADDR_W-1:0] word_sel;

  assign req      = ren ^ wen;
  assign wen_only = wen & ~ren;
  assign hit      = |wayHit;
  assign word_sel = (addr >> BYTE_W) & ADDR_W'(BLOCK_WORDS - 1);
  assign memDin   = cacheDout;

  // Hit way is the set wayHit bit; victim prefers the lowest invalid way over rr.
  always_comb begin
    hit_way   = '0;
    hit_found = 1'b0;
    victim    = rr;
    inv_found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!hit_found && wayHit[i]) begin
        hit_way   = WAY_W'(i);
        hit_found = 1'b1;
      end
      if (!inv_found && !wayValid[i]) begin
        victim    = WAY_W'(i);
        inv_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      vway  <= '0;
      rr    <= '0;
    end else begin
      state <= next_state;
      vway  <= vway_d;
      if (state == FILL)
        rr <= (WAYS == 1) ? '0 : rr + WAY_W'(1);
    end
  end

  // Every combinational output stays zero while reset is held low.
  always_comb begin
    next_state       = state;
    vway_d           = vway;
    stall            = 1'b0;
    dout             = '0;
    cacheWay         = vway;
    cacheRen         = 1'b0;
    cacheWen         = 1'b0;
    cacheFillWen     = 1'b0;
    cacheBytesAccess = '0;
    cacheDin         = '0;
    memRen           = 1'b0;
    memWen           = 1'b0;
    memAddr          = '0;
    if (reset) begin
      for (int w = 0; w < BLOCK_WORDS; w++)
        if (word_sel == ADDR_W'(w)) dout = cacheDout[w*WORD_W +: WORD_W];
      case (state)
        IDLE: begin
          if (req && hit) begin
            cacheWay = hit_way;
            cacheRen = ~wen;
            cacheWen = wen_only;
            if (wen_only) begin
              for (int w = 0; w < BLOCK_WORDS; w++) begin
                if (word_sel == ADDR_W'(w)) begin
                  cacheBytesAccess[w*NB +: NB]  = byteSel;
                  cacheDin[w*WORD_W +: WORD_W] = din;
                end
              end
            end
          end else if (req) begin
            stall      = 1'b1;
            vway_d     = victim;
            cacheWay   = victim;
            next_state = (wayValid[victim] && wayDirty[victim]) ? WRITEBACK : MEMREAD;
          end
        end
        WRITEBACK: begin
          stall   = 1'b1;
          memWen  = 1'b1;
          memAddr = {victimTag, addr[OFF_W +: SET_W]};
          if (memWriteDone) next_state = MEMREAD;
        end
        MEMREAD: begin
          stall   = 1'b1;
          memRen  = 1'b1;
          memAddr = addr[ADDR_W-1:OFF_W];
          if (memReadReady) next_state = FILL;
        end
        FILL: begin
          stall            = 1'b1;
          cacheFillWen     = 1'b1;
          cacheBytesAccess = '1;
          cacheDin         = memDout;
          // A write miss merges its bytes into the fill so the replay sees the final data.
          for (int w = 0; w < BLOCK_WORDS; w++)
            for (int b = 0; b < NB; b++)
              if (wen_only && word_sel == ADDR_W'(w) && byteSel[b])
                cacheDin[w*WORD_W + b*8 +: 8] = din[b*8 +: 8];
          next_state = REPLAY;
        end
        REPLAY: begin
          stall      = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic after_replay;

  // The IDLE cycle right after REPLAY completes a miss, so it is not counted as a hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hitCnt       <= '0;
      missCnt      <= '0;
      wbCnt        <= '0;
      after_replay <= 1'b0;
    end else begin
      after_replay <= (state == REPLAY);
      if (state == IDLE && req && hit && !after_replay && hitCnt != '1)
        hitCnt <= hitCnt + 32'd1;
      if (state == IDLE && req && !hit && missCnt != '1)
        missCnt <= missCnt + 32'd1;
      if (state == WRITEBACK && memWriteDone && wbCnt != '1)
        wbCnt <= wbCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// Directed self-checking bench for dcache_ctrl_nway at default parameters.
// Perf-counter checks are included when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_ctrl_nway;

  logic         clock, reset, ren, wen;
  logic [31:0]  addr, din, dout;
  logic [3:0]   byteSel;
  logic         stall;
  logic [1:0]   wayHit, wayValid, wayDirty;
  logic [19:0]  victimTag;
  logic [127:0] cacheDout, cacheDin, memDin, memDout;
  logic [0:0]   cacheWay;
  logic         cacheRen, cacheWen, cacheFillWen, memRen, memWen;
  logic [15:0]  cacheBytesAccess;
  logic [27:0]  memAddr;
  logic         memReadReady, memWriteDone;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hitCnt, missCnt, wbCnt;
`endif

  int num_checks = 0;
  int num_fail   = 0;

  localparam logic [127:0] CDOUT = 128'h44443333_33332222_22221111_11110000;
  localparam logic [127:0] MDOUT = 128'hF3F3F3F3_E2E2E2E2_D1D1D1D1_C0C0C0C0;

  dcache_ctrl_nway dut (
    .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .byteSel(byteSel), .din(din), .stall(stall), .dout(dout),
    .wayHit(wayHit), .wayValid(wayValid), .wayDirty(wayDirty),
    .victimTag(victimTag), .cacheDout(cacheDout), .cacheWay(cacheWay),
    .cacheRen(cacheRen), .cacheWen(cacheWen), .cacheFillWen(cacheFillWen),
    .cacheBytesAccess(cacheBytesAccess), .cacheDin(cacheDin),
    .memRen(memRen), .memWen(memWen), .memAddr(memAddr), .memDin(memDin),
    .memDout(memDout), .memReadReady(memReadReady), .memWriteDone(memWriteDone)
`ifdef DCACHE_PERF_CNT_EN
    , .hitCnt(hitCnt), .missCnt(missCnt), .wbCnt(wbCnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running required done");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [3:0] bs, input logic [31:0] d);
    ren = r; wen = w; addr = a; byteSel = bs; din = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0; memReadReady = 1'b0; memWriteDone = 1'b0;
    cacheDout = CDOUT; memDout = MDOUT; victimTag = 20'h0;
    wayHit = 2'b00; wayValid = 2'b11; wayDirty = 2'b00;
    applyStimulus(1'b1, 1'b0, 32'h0000_1238, 4'h0, 32'h0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_memRen", memRen, 0);
    checkOutput("rst_dout", dout, 0);

    // Read hit on way 1, word 2.
    tick();
    wayHit = 2'b10;
    reset  = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_1238, 4'h0, 32'h0);
    checkOutput("rdhit_way", cacheWay, 1);
    checkOutput("rdhit_stall", stall, 0);
    checkOutput("rdhit_ren", cacheRen, 1);
    checkOutput("rdhit_wen", cacheWen, 0);
    checkOutput("rdhit_dout", dout, 32'h33332222);

    // Write hit on way 0, word 1.
    wayHit = 2'b01;
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, 4'b0110, 32'hDEADBEEF);
    checkOutput("wrhit_way", cacheWay, 0);
    checkOutput("wrhit_wen", cacheWen, 1);
    checkOutput("wrhit_bytes", cacheBytesAccess, 16'h0060);
    checkOutput("wrhit_din", cacheDin, 128'h00000000_00000000_DEADBEEF_00000000);
    checkOutput("wrhit_stall", stall, 0);

    // ren and wen together is no request.
    wayHit = 2'b00;
    applyStimulus(1'b1, 1'b1, 32'h0000_1234, 4'b0110, 32'hDEADBEEF);
    checkOutput("both_stall", stall, 0);
    checkOutput("both_wen", cacheWen, 0);
    tick();
    checkOutput("both_stall_next", stall, 0);
    checkOutput("both_memRen_next", memRen, 0);

    // Clean miss, rr=0 -> way 0.
    wayValid = 2'b11; wayDirty = 2'b00;
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 4'h0, 32'h0);
    checkOutput("cm_idle_stall", stall, 1);
    checkOutput("cm_idle_way", cacheWay, 0);
    checkOutput("cm_idle_memRen", memRen, 0);
    tick(); #1;
    checkOutput("cm_mr_memRen", memRen, 1);
    checkOutput("cm_mr_addr", memAddr, 28'h1234567);
    checkOutput("cm_mr_way", cacheWay, 0);
    checkOutput("cm_mr_memWen", memWen, 0);
    memWriteDone = 1'b1;
    tick(); memWriteDone = 1'b0; #1;
    checkOutput("cm_ignore_wdone", memRen, 1);
    tick(); tick(); tick();
    memReadReady = 1'b1; #1;
    checkOutput("cm_mr_c5", memRen, 1);
    tick(); memReadReady = 1'b0; #1;
    checkOutput("cm_fill_wen", cacheFillWen, 1);
    checkOutput("cm_fill_bytes", cacheBytesAccess, 16'hFFFF);
    checkOutput("cm_fill_din", cacheDin, MDOUT);
    checkOutput("cm_fill_way", cacheWay, 0);
    checkOutput("cm_fill_memRen", memRen, 0);
    tick(); wayHit = 2'b01; #1;
    checkOutput("cm_replay_stall", stall, 1);
    checkOutput("cm_replay_fill", cacheFillWen, 0);
    checkOutput("cm_replay_way", cacheWay, 0);
    tick(); #1;
    checkOutput("cm_done_stall", stall, 0);
    checkOutput("cm_done_ren", cacheRen, 1);
    checkOutput("cm_done_dout", dout, 32'h33332222);

    // Dirty write miss; rr=1 now selects dirty way 1.
    wayHit = 2'b00; wayValid = 2'b11; wayDirty = 2'b10; victimTag = 20'hFACE1;
    applyStimulus(1'b0, 1'b1, 32'h0000_0AB4, 4'b0011, 32'hAABBCCDD);
    checkOutput("dm_idle_stall", stall, 1);
    checkOutput("dm_idle_way", cacheWay, 1);
    tick(); #1;
    checkOutput("dm_wb_memWen", memWen, 1);
    checkOutput("dm_wb_addr", memAddr, 28'hFACE1AB);
    checkOutput("dm_wb_way", cacheWay, 1);
    checkOutput("dm_wb_memRen", memRen, 0);
    memReadReady = 1'b1;
    tick(); memReadReady = 1'b0; #1;
    checkOutput("dm_ignore_rready", memWen, 1);
    memWriteDone = 1'b1;
    tick(); memWriteDone = 1'b0; #1;
    checkOutput("dm_mr_memRen", memRen, 1);
    checkOutput("dm_mr_memWen", memWen, 0);
    checkOutput("dm_mr_addr", memAddr, 28'h00000AB);
    memReadReady = 1'b1;
    tick(); memReadReady = 1'b0; #1;
    checkOutput("dm_fill_din", cacheDin, 128'hF3F3F3F3_E2E2E2E2_D1D1CCDD_C0C0C0C0);
    checkOutput("dm_fill_way", cacheWay, 1);
    checkOutput("dm_fill_wen", cacheFillWen, 1);
    tick(); wayHit = 2'b10; #1;
    checkOutput("dm_replay_stall", stall, 1);
    tick(); #1;
    checkOutput("dm_done_stall", stall, 0);
    checkOutput("dm_done_wen", cacheWen, 1);
    checkOutput("dm_done_way", cacheWay, 1);
    checkOutput("dm_done_bytes", cacheBytesAccess, 16'h0030);
    checkOutput("dm_done_din", cacheDin, 128'h00000000_00000000_AABBCCDD_00000000);
`ifdef DCACHE_PERF_CNT_EN
    checkOutput("perf_wbCnt", wbCnt, 1);
    checkOutput("perf_missCnt", missCnt, 2);
`endif

    // Reset in MEMREAD; way 1 invalid so it is the victim despite rr=0.
    wayHit = 2'b00; wayValid = 2'b01; wayDirty = 2'b00;
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 4'h0, 32'h0);
    checkOutput("rm_idle_way", cacheWay, 1);
    tick(); #1;
    checkOutput("rm_mr_memRen", memRen, 1);
    reset = 1'b0; #1;
    checkOutput("rm_rst_memRen", memRen, 0);
    checkOutput("rm_rst_stall", stall, 0);
`ifdef DCACHE_PERF_CNT_EN
    checkOutput("perf_rst_missCnt", missCnt, 0);
`endif
    tick();
    reset = 1'b1; #1;
    checkOutput("rm_rel_stall", stall, 1);
    checkOutput("rm_rel_memRen", memRen, 0);
    checkOutput("rm_rel_way", cacheWay, 1);
    tick(); #1;
    checkOutput("rm_restart_memRen", memRen, 1);
    checkOutput("rm_restart_addr", memAddr, 28'h1234567);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
